alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. It accepts one operation per valid/ready handshake, completes single-cycle ops in one clock and MUL/DIV iteratively over WIDTH clocks, and holds a registered result and flags until the consumer takes them. It sits between the register-file read stage and writeback. It also keeps a carry flag so that ADC chains multi-word adds.

---
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU, valid/ready in and out, stored carry for ADC chains.
// Define ALU_SEQ_DIV_EN to build the iterative divider for op 011 (else it is ADD).
module alu_seq #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status_reg
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t state_q, state_d;

    logic               accept, go_iter, go_div, last;
    logic [SHW-1:0]     cnt_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] prod_q, mcand_q, prod_nx, mul_full;
    logic [WIDTH-1:0]   sh_q, mag_a, mag_b;
    logic               mul_ovf;
    logic [WIDTH:0]     sum, diff, shl;
    logic               cin;
    logic [WIDTH-1:0]   sc_res, fin_res;
    logic               sc_c, sc_v, fin_c, fin_v;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign go_iter   = (op == OP_MUL) || go_div;
    assign last      = (cnt_q == SHW'(WIDTH-1));

    function automatic logic [3:0] flags(input logic [WIDTH-1:0] r,
                                         input logic c, input logic v);
        return {r == '0, r[WIDTH-1], c, v};
    endfunction

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   rem_q, div_b_q;
    logic               is_div_q;
    logic [2*WIDTH-1:0] div_acc, div_it;

    // One restoring step; returns {remainder, quotient-so-far}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] t;
        t = {r, q[WIDTH-1]};
        if (t >= {1'b0, d})
            return {WIDTH'(t - {1'b0, d}), q[WIDTH-2:0], 1'b1};
        return {t[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    assign go_div  = (op == OP_DIV) && (data2 != '0);
    assign div_acc = div_step('0, data1, data2);
    assign div_it  = div_step(rem_q, sh_q, div_b_q);
`else
    assign go_div = 1'b0;
`endif

    assign cin  = (op == OP_ADC) ? status_reg[1] : 1'b0;
    assign sum  = {1'b0, data1} + {1'b0, data2} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, data1} - {1'b0, data2};
    assign shl  = {1'b0, data1} << data2;

    always_comb begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                 (sum[WIDTH-1] != data1[WIDTH-1]);
        unique case (op)
            OP_SUB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
                sc_v   = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                         (diff[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_AND: begin
                sc_res = data1 & data2;
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
            OP_SHL: begin
                sc_res = shl[WIDTH-1:0];
                sc_c   = shl[WIDTH];
                sc_v   = 1'b0;
            end
            OP_PASS: begin
                sc_res = data1;
                sc_c   = status_reg[1];
                sc_v   = status_reg[0];
            end
            OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                sc_res = '1;
                sc_c   = 1'b0;
                sc_v   = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign mag_a = data1[WIDTH-1] ? -data1 : data1;
    assign mag_b = data2[WIDTH-1] ? -data2 : data2;

    // Magnitude shift-add; sign restored on the final step.
    assign prod_nx  = prod_q + (sh_q[0] ? mcand_q : '0);
    assign mul_full = neg_q ? -prod_nx : prod_nx;
    assign mul_ovf  = !((&mul_full[2*WIDTH-1:WIDTH-1]) ||
                        !(|mul_full[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        fin_res = mul_full[WIDTH-1:0];
        fin_c   = mul_ovf;
        fin_v   = mul_ovf;
`ifdef ALU_SEQ_DIV_EN
        if (is_div_q) begin
            fin_res = div_it[WIDTH-1:0];
            fin_c   = |div_it[2*WIDTH-1:WIDTH];
            fin_v   = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = go_iter ? ITER : DONE;
            ITER:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Bit 0 of MUL/DIV is done on the accept edge, so ITER lasts WIDTH-1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            status_reg <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            prod_q     <= '0;
            mcand_q    <= '0;
            sh_q       <= '0;
`ifdef ALU_SEQ_DIV_EN
            rem_q      <= '0;
            div_b_q    <= '0;
            is_div_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    cnt_q   <= SHW'(1);
                    neg_q   <= data1[WIDTH-1] ^ data2[WIDTH-1];
                    prod_q  <= mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
                    mcand_q <= {{WIDTH{1'b0}}, mag_a} << 1;
                    sh_q    <= mag_b >> 1;
`ifdef ALU_SEQ_DIV_EN
                    is_div_q <= go_div;
                    div_b_q  <= data2;
                    if (go_div) {rem_q, sh_q} <= div_acc;
`endif
                    if (!go_iter) begin
                        result     <= sc_res;
                        status_reg <= flags(sc_res, sc_c, sc_v);
                    end
                end
                ITER: begin
                    cnt_q   <= cnt_q + SHW'(1);
                    prod_q  <= prod_nx;
                    mcand_q <= mcand_q << 1;
                    sh_q    <= sh_q >> 1;
`ifdef ALU_SEQ_DIV_EN
                    if (is_div_q) {rem_q, sh_q} <= div_it;
`endif
                    if (last) begin
                        result     <= fin_res;
                        status_reg <= flags(fin_res, fin_c, fin_v);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random ops against alu_seq (WIDTH=16), queue scoreboard.
// Build with or without ALU_SEQ_DIV_EN; the reference model follows the macro.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] data1, data2, result;
    logic [3:0]   status_reg;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_flg;
    int         n_total = 0;
    int         n_pass  = 0;
    int         seen;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .data1(data1), .data2(data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .status_reg(status_reg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] fl);
        exp_t   e;
        int     s, ss, sh;
        longint p;
        logic   c, v;
        logic [2:0] oo;
        oo = o;
`ifndef ALU_SEQ_DIV_EN
        if (o == 3'b011) oo = 3'b000;
`endif
        e.lat = 1; e.res = '0; c = 1'b0; v = 1'b0;
        case (oo)
            3'b000, 3'b001: begin
                s  = int'(a) + int'(b) + ((oo == 3'b001) ? int'(fl[1]) : 0);
                ss = int'($signed(a)) + int'($signed(b)) + ((oo == 3'b001) ? int'(fl[1]) : 0);
                e.res = s[15:0];
                c = (s > 65535);
                v = (ss > 32767) || (ss < -32768);
            end
            3'b010: begin
                ss = int'($signed(a)) - int'($signed(b));
                e.res = a - b;
                c = (a < b);
                v = (ss > 32767) || (ss < -32768);
            end
            3'b011: begin
                if (b == 0) begin
                    e.res = 16'hFFFF; v = 1'b1;
                end else begin
                    e.res = a / b; c = ((a % b) != 0); e.lat = 16;
                end
            end
            3'b100: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.res = p[15:0];
                c = (p > 32767) || (p < -32768);
                v = c;
                e.lat = 16;
            end
            3'b101: e.res = a & b;
            3'b110: begin
                sh = int'(b);
                if (sh == 0) e.res = a;
                else if (sh <= 16) begin
                    e.res = (sh == 16) ? 16'h0 : (a << sh);
                    c = a[16-sh];
                end
            end
            default: begin
                e.res = a; c = fl[1]; v = fl[0];
            end
        endcase
        e.flg = {e.res == 16'h0, e.res[15], c, v};
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int stall);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk({tag, "/ready"}, 32'(in_ready), 32'd1);
        e = model(o, a, b, m_flg);
        sb.push_back(e);
        m_flg = e.flg;
        in_valid = 1'b1; op = o; data1 = a; data2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); data1 = 16'($urandom); data2 = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "/latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "/result"}, 32'(result), 32'(e.res));
        chk({tag, "/flags"}, 32'(status_reg), 32'(e.flg));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold"}, {14'h0, out_valid, in_ready, result}, {14'h0, 2'b10, e.res});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/drop"}, {30'h0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; data1 = '0; data2 = '0; m_flg = '0;
        repeat (2) @(negedge clk);
        chk("reset/ctl", {30'h0, in_ready, out_valid}, 32'd0);
        chk("reset/result", 32'(result), 32'd0);
        chk("reset/flags", 32'(status_reg), 32'd0);
        rst = 1'b0;

        run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 0);
        run_op("add_lo",  3'b000, 16'hFFFF, 16'h0001, 0);
        run_op("adc_hi",  3'b001, 16'h0001, 16'h0000, 0);
        run_op("mul_neg", 3'b100, 16'hFFFD, 16'h0007, 0);
        run_op("mul_ovf", 3'b100, 16'h4000, 16'h0004, 0);
        run_op("div",     3'b011, 16'd100,  16'd7,    0);
        run_op("div0",    3'b011, 16'd5,    16'd0,    0);
        run_op("sub_brw", 3'b010, 16'h0003, 16'h0005, 0);
        run_op("sub_ovf", 3'b010, 16'h8000, 16'h0001, 0);
        run_op("and",     3'b101, 16'hF0F0, 16'h3C3C, 0);
        run_op("shl1",    3'b110, 16'h8001, 16'h0001, 0);
        run_op("shl0",    3'b110, 16'h1234, 16'h0000, 0);
        run_op("shl16",   3'b110, 16'h0001, 16'h0010, 0);
        run_op("pass",    3'b111, 16'h8000, 16'h0000, 0);
        run_op("shl20",   3'b110, 16'hFFFF, 16'h0014, 0);
        run_op("mul_min", 3'b100, 16'h8000, 16'h8000, 5);
        run_op("add_bp",  3'b000, 16'hFFFF, 16'hFFFF, 3);
        run_op("pass_c",  3'b111, 16'h0000, 16'h1111, 0);
        run_op("adc_c",   3'b001, 16'h0010, 16'h0020, 0);

        for (int i = 0; i < 10; i++)
            run_op("rand", 3'($urandom_range(0, 7)), 16'($urandom),
                   (i % 2 == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom), i % 3);

        // Reset three cycles into a MUL must abort it.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b100; data1 = 16'h7123; data2 = 16'h0F55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid/ctl", {30'h0, in_ready, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_flg = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_mid/no_valid", 32'(seen), 32'd0);
        chk("rst_mid/flags", 32'(status_reg), 32'd0);
        chk("rst_mid/result", 32'(result), 32'd0);
        chk("rst_mid/ready", 32'(in_ready), 32'd1);
        run_op("adc_after_rst", 3'b001, 16'h0001, 16'h0001, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
